mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised memory-port arbiter that merges `PORTS` independent request channels onto one external memory bus. Each channel has the same shape as the core's instruction-fetch, data-read and data-write ports. It replaces the core's three dedicated memory ports with one shared bus, so a single-ported memory can serve fetch, read and write stages. It adds selectable fixed-priority or round-robin arbitration, mixed read/write channels and a transaction timeout. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `PORTS`, 3: number of requester channels, 1..8.
- `WIDTH`, 32: address and data width; matches `regval_t`.
- `MODE`, `ARB_ROUND_ROBIN`: arbitration mode, either `ARB_FIXED` or `ARB_ROUND_ROBIN`.
- `TIMEOUT`, 255: number of `BUSY` cycles before abort; 0 disables the timeout.

Ports (the `[PORTS]` arrays are unpacked):
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address[PORTS]` input WIDTH: request address per channel.
- `address_enable[PORTS]` input 1: request level; held until `data_valid` or `error`.
- `write_enable[PORTS]` input 1: 1 selects write, 0 selects read; sampled with the request.
- `data_out[PORTS]` input WIDTH: write data per channel.
- `data_in` output WIDTH: read data, shared by all channels and qualified by `data_valid`.
- `data_valid[PORTS]` output 1: one-cycle completion pulse to the granted channel.
- `error[PORTS]` output 1: one-cycle timeout pulse to the granted channel.
- `mem_address` output WIDTH: bus address.
- `mem_read` output 1: read strobe, held until `mem_ready`.
- `mem_write` output 1: write strobe, held until `mem_ready`.
- `mem_write_data` output WIDTH: bus write data.
- `mem_read_data` input WIDTH: bus read data, valid with `mem_ready`.
- `mem_ready` input 1: bus acknowledge for the current strobe.

## Operation
- State machine `IDLE` → `BUSY` → `DONE` → `IDLE`.
- `IDLE`:
  - If any `address_enable` is high, choose `grant`.
  - Register `address`, `data_out` and `write_enable` of the granted channel.
  - Assert `mem_read` or `mem_write`, clear the timeout counter and go to `BUSY`.
  - With no request, stay in `IDLE`.
- `BUSY`, on `mem_ready`:
  - Drop both strobes.
  - For a read, capture `mem_read_data` into `data_in`.
  - Pulse `data_valid[grant]` and go to `DONE`.
- `BUSY`, timeout (`TIMEOUT`≠0 and counter reaches `TIMEOUT` without `mem_ready`):
  - Drop both strobes, pulse `error[grant]`; `data_in` is unchanged. Go to `DONE`.
  - `mem_ready` in the same cycle as the timeout takes precedence: the transaction completes normally.
- `DONE`: ignore all requests for one cycle, then go to `IDLE`. This gives a registered requester time to drop its enable.
- `ARB_FIXED`: the lowest-index requesting channel wins.
- `ARB_ROUND_ROBIN`:
  - Search starts at `last+1` modulo `PORTS`; `last` updates on every grant.
  - `last` resets to `PORTS-1`, so channel 0 has first priority.
- A channel that drops `address_enable` while granted does not abort the transaction; its `data_valid` still pulses.
- `write_enable` and `data_out` changes after the grant are ignored.
- `PORTS`=1 degenerates to a registered pass-through with the same timing.

## Timing
- Reset values:
  - state `IDLE`, `grant` = 0, `last` = `PORTS-1`, counter 0.
  - All strobes, `data_valid`, `error`, `data_in`, `mem_address` and `mem_write_data` are 0.
- A request sampled at edge E0 drives the strobes from E0 onward.
- `mem_ready` sampled at edge Ek drops the strobes and raises `data_valid` for the cycle between Ek and Ek+1.
- The next grant is sampled no earlier than Ek+2.
- Minimum cost is 3 cycles per transaction, with `mem_ready` at E1.
- The timeout counter increments each `BUSY` cycle. Its width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.
- All outputs are registered; there are no combinational input-to-output paths.
- Reset asserted mid-transaction:
  - Strobes drop immediately and any pending `data_valid` is lost.
  - The state machine returns to `IDLE` and `last` returns to `PORTS-1`.

## Structure
- Shared core package gains:
  - enum `arb_mode_t` with `ARB_FIXED` and `ARB_ROUND_ROBIN`.
  - enum `arb_state_t` with `IDLE`, `BUSY` and `DONE`.
- `regval_t` is reused when `WIDTH`=32.
- Sub-module `rr_picker`: combinational one-hot and index selector.
  - Inputs: request vector, start index and mode.
  - Outputs: `any`, `index`.
  - Reused later by the multi-core bus.

## Test plan
- Single read: channel 1 requests address 0x40; memory returns 0xDEADBEEF with `mem_ready` at E3. Required: `mem_read` high for E0–E3, `data_in`=0xDEADBEEF, `data_valid[1]` pulsed once after E3, no other channel pulsed.
- Round-robin: all 3 channels request continuously, memory ready at E1. Required: grants 0,1,2,0,1,2, one every 3 cycles. With `ARB_FIXED` and the same stimulus: channel 0 is granted every time.
- Write: channel 2 writes 0x12345678 to 0x100. Required: `mem_write`=1, `mem_address`=0x100, `mem_write_data`=0x12345678; `data_in` unchanged; `data_valid[2]` pulses.
- Timeout: `TIMEOUT`=4, no `mem_ready`. Required: strobe high for 4 `BUSY` cycles, then `error[grant]` pulses once and `data_valid` stays 0. A second run with `mem_ready` on the 4th `BUSY` cycle must complete normally.
- Reset mid-`BUSY`: assert `reset_n`=0 asynchronously between edges. Required: strobes fall without waiting for a clock edge, all outputs are 0, and the first grant after release goes to channel 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the memory-port arbiter and its picker.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational requester picker, fixed or rotating priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int PORTS = 3,
  parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [IW-1:0]    i_start,
  input  arb_mode_t        i_mode,
  output logic             o_any,
  output logic [IW-1:0]    o_index
);

  localparam logic [IW:0] c_ports = (IW+1)'(PORTS);

  logic [IW-1:0]      w_base;
  logic [2*PORTS-1:0] w_dbl;
  logic [PORTS-1:0]   w_rot;
  logic [IW-1:0]      w_off;
  logic [IW:0]        w_sum;

  // Rotate so the search origin sits at bit 0, then take the lowest set bit.
  assign w_base = (i_mode == ARB_FIXED) ? '0 : i_start;
  assign w_dbl  = {i_req, i_req} >> w_base;
  assign w_rot  = w_dbl[PORTS-1:0];

  always_comb begin
    w_off = '0;
    for (int j = PORTS - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = IW'(j);
    end
  end

  assign w_sum   = {1'b0, w_base} + {1'b0, w_off};
  assign o_any   = |i_req;
  assign o_index = (w_sum >= c_ports) ? IW'(w_sum - c_ports) : w_sum[IW-1:0];

endmodule : rr_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Merges PORTS request channels onto one memory bus, one
//               outstanding transaction, fixed/round-robin with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int        PORTS   = 3,
  parameter int        WIDTH   = 32,
  parameter arb_mode_t MODE    = ARB_ROUND_ROBIN,
  parameter int        TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] address        [PORTS],
  input  logic             address_enable [PORTS],
  input  logic             write_enable   [PORTS],
  input  logic [WIDTH-1:0] data_out       [PORTS],
  output logic [WIDTH-1:0] data_in,
  output logic             data_valid     [PORTS],
  output logic             error          [PORTS],
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  input  logic             mem_ready
);

  localparam int             IW          = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int             CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0]  c_last_init = IW'(PORTS - 1);
  localparam logic [CW-1:0]  c_timeout   = CW'(TIMEOUT);
  localparam logic [CW-1:0]  c_cnt_max   = '1;

  arb_state_t       r_state;
  logic [IW-1:0]    r_grant;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic             r_rd;
  logic             r_wr;
  logic             r_we;
  logic [PORTS-1:0] r_valid;
  logic [PORTS-1:0] r_err;
  logic [WIDTH-1:0] r_data_in;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;

  logic [PORTS-1:0] w_req;
  logic [IW-1:0]    w_start;
  logic             w_any;
  logic [IW-1:0]    w_pick;
  logic [CW-1:0]    w_cnt_next;
  logic             w_timeout;

  for (genvar i = 0; i < PORTS; i++) begin : g_chan
    assign w_req[i]      = address_enable[i];
    assign data_valid[i] = r_valid[i];
    assign error[i]      = r_err[i];
  end

  assign w_start = (r_last == c_last_init) ? '0 : r_last + 1'b1;

  rr_picker #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_picker (
    .i_req   (w_req),
    .i_start (w_start),
    .i_mode  (MODE),
    .o_any   (w_any),
    .o_index (w_pick)
  );

  // Saturating count of BUSY cycles; never wraps back into a false timeout.
  assign w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_timeout);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= c_last_init;
      r_cnt     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_we      <= 1'b0;
      r_valid   <= '0;
      r_err     <= '0;
      r_data_in <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_valid <= '0;
      r_err   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_addr  <= address[w_pick];
            r_wdata <= data_out[w_pick];
            r_we    <= write_enable[w_pick];
            r_rd    <= !write_enable[w_pick];
            r_wr    <= write_enable[w_pick];
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // A ready arriving on the timeout cycle still completes normally.
          if (mem_ready) begin
            r_rd             <= 1'b0;
            r_wr             <= 1'b0;
            r_valid[r_grant] <= 1'b1;
            if (!r_we) r_data_in <= mem_read_data;
            r_state          <= DONE;
          end else begin
            r_cnt <= w_cnt_next;
            if (w_timeout) begin
              r_rd           <= 1'b0;
              r_wr           <= 1'b0;
              r_err[r_grant] <= 1'b1;
              r_state        <= DONE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_in        = r_data_in;
  assign mem_address    = r_addr;
  assign mem_read       = r_rd;
  assign mem_write      = r_wr;
  assign mem_write_data = r_wdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench, round-robin and fixed instances side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int P  = 3;
  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] address        [P];
  logic        address_enable [P];
  logic        write_enable   [P];
  logic [31:0] data_out       [P];
  logic [31:0] mem_read_data;
  logic        mem_ready;

  logic [31:0] rr_din, rr_maddr, rr_mwd, fx_din, fx_maddr, fx_mwd;
  logic        rr_rd, rr_wr, fx_rd, fx_wr;
  logic        rr_dv [P], rr_er [P], fx_dv [P], fx_er [P];

  mem_port_arbiter #(.PORTS(P), .WIDTH(32), .MODE(ARB_ROUND_ROBIN), .TIMEOUT(TO)) u_rr (
    .clock(clock), .reset_n(reset_n), .address(address), .address_enable(address_enable),
    .write_enable(write_enable), .data_out(data_out), .data_in(rr_din), .data_valid(rr_dv),
    .error(rr_er), .mem_address(rr_maddr), .mem_read(rr_rd), .mem_write(rr_wr),
    .mem_write_data(rr_mwd), .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  mem_port_arbiter #(.PORTS(P), .WIDTH(32), .MODE(ARB_FIXED), .TIMEOUT(TO)) u_fx (
    .clock(clock), .reset_n(reset_n), .address(address), .address_enable(address_enable),
    .write_enable(write_enable), .data_out(data_out), .data_in(fx_din), .data_valid(fx_dv),
    .error(fx_er), .mem_address(fx_maddr), .mem_read(fx_rd), .mem_write(fx_wr),
    .mem_write_data(fx_mwd), .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  int      n_chk = 0;
  int      n_err = 0;
  int      rr_last;
  regval_t m_rr_din, m_fx_din;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pack3(input logic v [P]);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < P; i++) r[i] = v[i];
    return r;
  endfunction

  // Reference rule: scan channels from 'start' upward, wrapping modulo P.
  function automatic int pick(input logic [2:0] m, input int start);
    for (int k = 0; k < P; k++) begin
      if (m[(start + k) % P]) return (start + k) % P;
    end
    return 0;
  endfunction

  function automatic logic [2:0] onehot(input int g);
    logic [2:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic chk_all_zero(input string tag);
    check_val({tag, "_rr_strobes"}, {30'd0, rr_rd, rr_wr}, 32'd0);
    check_val({tag, "_fx_strobes"}, {30'd0, fx_rd, fx_wr}, 32'd0);
    check_val({tag, "_rr_din"}, rr_din, 32'd0);
    check_val({tag, "_rr_maddr"}, rr_maddr, 32'd0);
    check_val({tag, "_rr_mwd"}, rr_mwd, 32'd0);
    check_val({tag, "_fx_din"}, fx_din, 32'd0);
    check_val({tag, "_rr_dv_er"}, {26'd0, pack3(rr_dv), pack3(rr_er)}, 32'd0);
    check_val({tag, "_fx_dv_er"}, {26'd0, pack3(fx_dv), pack3(fx_er)}, 32'd0);
  endtask

  // One transaction from request to the cycle after completion.
  // lat: cycles from grant edge to mem_ready edge; 0 means never ready.
  task automatic do_txn(input logic [2:0] mask, input int lat, input logic [31:0] rdata,
                        output logic [2:0] rr_seen, output logic [2:0] fx_seen);
    int g_rr, g_fx, n_end;
    logic ok, we_rr, we_fx;
    logic [31:0] a_rr, a_fx, d_rr, d_fx;
    for (int ch = 0; ch < P; ch++) address_enable[ch] = mask[ch];
    g_rr    = pick(mask, (rr_last + 1) % P);
    g_fx    = pick(mask, 0);
    rr_last = g_rr;
    we_rr = write_enable[g_rr]; a_rr = address[g_rr]; d_rr = data_out[g_rr];
    we_fx = write_enable[g_fx]; a_fx = address[g_fx]; d_fx = data_out[g_fx];
    ok    = (lat >= 1) && (lat <= TO);
    n_end = ok ? lat : TO;

    @(posedge clock); #1;
    check_val("grant_rr_rd", {31'd0, rr_rd}, {31'd0, !we_rr});
    check_val("grant_rr_wr", {31'd0, rr_wr}, {31'd0, we_rr});
    check_val("grant_rr_addr", rr_maddr, a_rr);
    if (we_rr) check_val("grant_rr_wdata", rr_mwd, d_rr);
    check_val("grant_fx_rd", {31'd0, fx_rd}, {31'd0, !we_fx});
    check_val("grant_fx_wr", {31'd0, fx_wr}, {31'd0, we_fx});
    check_val("grant_fx_addr", fx_maddr, a_fx);

    for (int c = 1; c <= n_end; c++) begin
      if (c == n_end && ok) begin
        mem_ready     = 1'b1;
        mem_read_data = rdata;
      end else begin
        mem_read_data = $urandom;
      end
      // Post-grant changes on every channel must be ignored.
      for (int ch = 0; ch < P; ch++) begin
        write_enable[ch] = 1'($urandom);
        data_out[ch]     = $urandom;
        address[ch]      = $urandom;
        if ($urandom_range(0, 3) == 0) address_enable[ch] = 1'b0;
      end
      @(posedge clock); #1;
      mem_ready = 1'b0;
      if (c < n_end) begin
        check_val("busy_rr_strobe", {30'd0, rr_rd, rr_wr}, {30'd0, !we_rr, we_rr});
        check_val("busy_fx_strobe", {30'd0, fx_rd, fx_wr}, {30'd0, !we_fx, we_fx});
        check_val("busy_rr_addr", rr_maddr, a_rr);
        check_val("busy_dv_er", {26'd0, pack3(rr_dv), pack3(fx_dv)}, 32'd0);
      end else begin
        if (ok && !we_rr) m_rr_din = rdata;
        if (ok && !we_fx) m_fx_din = rdata;
        check_val("end_rr_strobe", {30'd0, rr_rd, rr_wr}, 32'd0);
        check_val("end_fx_strobe", {30'd0, fx_rd, fx_wr}, 32'd0);
        check_val("end_rr_dv", {29'd0, pack3(rr_dv)}, ok ? {29'd0, onehot(g_rr)} : 32'd0);
        check_val("end_rr_er", {29'd0, pack3(rr_er)}, ok ? 32'd0 : {29'd0, onehot(g_rr)});
        check_val("end_fx_dv", {29'd0, pack3(fx_dv)}, ok ? {29'd0, onehot(g_fx)} : 32'd0);
        check_val("end_fx_er", {29'd0, pack3(fx_er)}, ok ? 32'd0 : {29'd0, onehot(g_fx)});
        check_val("end_rr_din", rr_din, m_rr_din);
        check_val("end_fx_din", fx_din, m_fx_din);
        rr_seen = pack3(rr_dv);
        fx_seen = pack3(fx_dv);
      end
    end

    // Requests are still present here; no grant may be taken during this cycle.
    for (int ch = 0; ch < P; ch++) address_enable[ch] = 1'b1;
    @(posedge clock); #1;
    check_val("done_strobes", {28'd0, rr_rd, rr_wr, fx_rd, fx_wr}, 32'd0);
    check_val("done_pulses", {20'd0, pack3(rr_dv), pack3(rr_er), pack3(fx_dv), pack3(fx_er)}, 32'd0);
  endtask

  task automatic set_chan(input int ch, input logic we, input logic [31:0] a, input logic [31:0] d);
    write_enable[ch] = we;
    address[ch]      = a;
    data_out[ch]     = d;
  endtask

  logic [2:0] s_rr, s_fx;
  int         exp_seq [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    for (int ch = 0; ch < P; ch++) begin
      address_enable[ch] = 1'b0;
      set_chan(ch, 1'b0, 32'd0, 32'd0);
    end
    mem_ready     = 1'b0;
    mem_read_data = 32'd0;
    rr_last  = P - 1;
    m_rr_din = '0;
    m_fx_din = '0;

    @(posedge clock); #1;
    chk_all_zero("reset");
    #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // Single read on channel 1.
    set_chan(1, 1'b0, 32'h40, 32'h0);
    do_txn(3'b010, 3, 32'hDEADBEEF, s_rr, s_fx);
    check_val("read_ch1_dv", {29'd0, s_rr}, 32'd2);
    check_val("read_ch1_data", rr_din, 32'hDEADBEEF);

    // Write on channel 2; data_in must keep the previous read value.
    set_chan(2, 1'b1, 32'h100, 32'h12345678);
    do_txn(3'b100, 2, 32'hA5A5A5A5, s_rr, s_fx);
    check_val("write_ch2_dv", {29'd0, s_rr}, 32'd4);
    check_val("write_keeps_din", rr_din, 32'hDEADBEEF);

    set_chan(0, 1'b0, 32'h8, 32'h0);
    do_txn(3'b001, 1, 32'h0000_1111, s_rr, s_fx);

    // Reset in the middle of BUSY, between clock edges.
    for (int ch = 0; ch < P; ch++) set_chan(ch, 1'b0, 32'h200 + 32'(ch), 32'h0);
    for (int ch = 0; ch < P; ch++) address_enable[ch] = 1'b1;
    @(posedge clock); #1;
    check_val("pre_reset_busy", {30'd0, rr_rd, fx_rd}, 32'd3);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    rr_last  = P - 1;
    m_rr_din = '0;
    m_fx_din = '0;
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    do_txn(3'b111, 1, 32'h0BAD_F00D, s_rr, s_fx);
    check_val("post_reset_grant0", {29'd0, s_rr}, 32'd1);

    // Continuous requests from all channels, ready one cycle after each grant.
    for (int i = 0; i < 2; i++) do_txn(3'b111, 1, $urandom, s_rr, s_fx);
    for (int i = 0; i < 6; i++) begin
      do_txn(3'b111, 1, $urandom, s_rr, s_fx);
      check_val("rr_sequence", {29'd0, s_rr}, {29'd0, onehot(exp_seq[i])});
      check_val("fixed_always0", {29'd0, s_fx}, 32'd1);
    end

    // Timeout with no ready, then ready exactly on the timeout cycle.
    do_txn(3'b011, 0, $urandom, s_rr, s_fx);
    do_txn(3'b011, TO, 32'hCAFE_0004, s_rr, s_fx);

    for (int n = 0; n < 40; n++) begin
      for (int ch = 0; ch < P; ch++) set_chan(ch, 1'($urandom), $urandom, $urandom);
      do_txn(3'($urandom_range(1, 7)), $urandom_range(0, 6), $urandom, s_rr, s_fx);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
